// File: rtl/mt_gshare_bht_pkg.sv
// Shared types and helpers for the multi-thread gshare branch history table.
package bht_pkg;

    // Two-bit saturating direction counter; MSB is the predicted direction.
    typedef logic [1:0] bht_ctr_t;

    // Counters come out of reset and clear as weakly not-taken.
    localparam bht_ctr_t BHT_CTR_RST = 2'b01;

    typedef enum logic {BHT_IDLE, BHT_CLEAR} bht_state_e;

    // Wide enough for any table index; callers truncate to their own IDX_W.
    localparam int unsigned BHT_IDX_MAX_W = 32;
    typedef logic [BHT_IDX_MAX_W-1:0] bht_idx_t;

    // gshare index: PC bits XOR history aligned to the top of the index.
    function automatic bht_idx_t bht_index(input bht_idx_t pc_bits,
                                           input bht_idx_t hist,
                                           input int unsigned hist_shift);
        return pc_bits ^ (hist << hist_shift);
    endfunction

    // Saturating +1 / -1 in the range 0..3, never wrapping.
    function automatic bht_ctr_t bht_ctr_sat(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/mt_gshare_bht_ghr.sv
// Per-thread speculative global history register.
// Priority: clear > restore > shift.
module gshare_ghr
    import bht_pkg::*;
#(
    parameter int unsigned HIST_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 restore_en,
    input  logic [HIST_BITS-1:0] restore_val,
    input  logic                 shift_en,
    input  logic                 shift_bit,
    output logic [HIST_BITS-1:0] ghr
);

    logic [HIST_BITS-1:0] ghr_reg;

    // History register; truncating {ghr, bit} keeps the newest HIST_BITS bits,
    // which also covers the single-bit history case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (clear) begin
            ghr_reg <= '0;
        end else if (restore_en) begin
            ghr_reg <= restore_val;
        end else if (shift_en) begin
            ghr_reg <= HIST_BITS'({ghr_reg, shift_bit});
        end
    end

    assign ghr = ghr_reg;

endmodule

// File: rtl/mt_gshare_bht.sv
// Multi-thread gshare branch history table: counter array, saturating
// update, per-thread speculative history and a sequential clear engine.
module mt_gshare_bht
    import bht_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = 32,
    parameter int unsigned HIST_BITS   = 3,
    parameter int unsigned NUM_THREADS = 1,
    parameter int unsigned VLEN        = 32,
    parameter int unsigned PC_OFFSET   = 1,
    localparam int unsigned IDX_W      = $clog2(NR_ENTRIES),
    localparam int unsigned TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    input  logic                 lookup_valid_i,
    input  logic [TID_W-1:0]     lookup_tid_i,
    input  logic [VLEN-1:0]      lookup_pc_i,
    output logic                 lookup_taken_o,
    output logic [HIST_BITS-1:0] lookup_hist_o,
    input  logic                 update_valid_i,
    input  logic [TID_W-1:0]     update_tid_i,
    input  logic [VLEN-1:0]      update_pc_i,
    input  logic [HIST_BITS-1:0] update_hist_i,
    input  logic                 update_taken_i,
    input  logic                 update_mispredict_i
);

    // Thread ids are decoded over the full TID_W range; slots beyond
    // NUM_THREADS read as an all-zero history.
    localparam int unsigned NUM_TID_SLOTS = 1 << TID_W;

    bht_state_e           state_reg, state_next;
    logic [IDX_W-1:0]     clr_idx_reg, clr_idx_next;
    logic                 clear_we;

    bht_ctr_t             ctr_table_reg [NR_ENTRIES];
    logic [HIST_BITS-1:0] ghr_all [NUM_TID_SLOTS];

    logic [HIST_BITS-1:0] lk_hist;
    logic [IDX_W-1:0]     lk_idx;
    logic [IDX_W-1:0]     up_idx;
    bht_ctr_t             up_ctr_next;
    logic [HIST_BITS-1:0] restore_val;

    // Only the indexed PC slice is used; the remaining bits are intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

    // ---------------- index and lookup ----------------
    assign lk_hist = ghr_all[lookup_tid_i];
    assign lk_idx  = IDX_W'(bht_index(bht_idx_t'(lookup_pc_i[PC_OFFSET +: IDX_W]),
                                      bht_idx_t'(lk_hist), IDX_W - HIST_BITS));
    assign up_idx  = IDX_W'(bht_index(bht_idx_t'(update_pc_i[PC_OFFSET +: IDX_W]),
                                      bht_idx_t'(update_hist_i), IDX_W - HIST_BITS));

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign lookup_taken_o = ready_o & ctr_table_reg[lk_idx][1];
    assign lookup_hist_o  = ready_o ? lk_hist : '0;

    assign up_ctr_next = bht_ctr_sat(ctr_table_reg[up_idx], update_taken_i);
    assign restore_val = HIST_BITS'({update_hist_i, update_taken_i});

    // ---------------- per-thread history ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TID_SLOTS; gi++) begin : g_thread
            if (gi < NUM_THREADS) begin : g_ghr
                gshare_ghr #(
                    .HIST_BITS (HIST_BITS)
                ) u_ghr (
                    .clk         (clk_i),
                    .rst         (rst_i),
                    .clear       (flush_i),
                    .restore_en  (update_valid_i & ready_o & update_mispredict_i &
                                  (update_tid_i == TID_W'(gi))),
                    .restore_val (restore_val),
                    .shift_en    (lookup_valid_i & ready_o & (lookup_tid_i == TID_W'(gi))),
                    .shift_bit   (lookup_taken_o),
                    .ghr         (ghr_all[gi])
                );
            end else begin : g_unused
                assign ghr_all[gi] = '0;
            end
        end
    endgenerate

    // ---------------- counter table ----------------
    // Clear engine owns the write port while running; otherwise resolved branches train it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                ctr_table_reg[i] <= BHT_CTR_RST;
            end
        end else if (clear_we) begin
            ctr_table_reg[clr_idx_reg] <= BHT_CTR_RST;
        end else if (update_valid_i && ready_o) begin
            ctr_table_reg[up_idx] <= up_ctr_next;
        end
    end

    // ---------------- clear FSM ----------------
    // State and clear pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= BHT_IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Next state: a flush (re)starts from entry 0; the last entry returns to IDLE
    // instead of letting the pointer wrap.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            BHT_IDLE: begin
                if (flush_i) begin
                    state_next   = BHT_CLEAR;
                    clr_idx_next = '0;
                end
            end
            BHT_CLEAR: begin
                if (flush_i) begin
                    clr_idx_next = '0;
                end else if (clr_idx_reg == IDX_W'(NR_ENTRIES - 1)) begin
                    state_next   = BHT_IDLE;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next   = BHT_IDLE;
                clr_idx_next = '0;
            end
        endcase
    end

    // Outputs: ready only while idle; table write strobe while clearing.
    always_comb begin
        ready_o  = 1'b0;
        clear_we = 1'b0;
        case (state_reg)
            BHT_IDLE:  ready_o  = 1'b1;
            BHT_CLEAR: clear_we = 1'b1;
            default:   ready_o  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mt_gshare_bht.sv
// Bench for mt_gshare_bht: directed vectors on a 2-thread / 3-bit history
// instance, plus a reference-model sweep on a 4-thread / 1-bit history instance.
module tb_mt_gshare_bht;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;

    // ---------------- instance A: 32 entries, 3-bit history, 2 threads ----------------
    logic        a_flush, a_ready, a_lv, a_ltid, a_taken, a_uv, a_utid, a_ut, a_um;
    logic [31:0] a_lpc, a_upc;
    logic [2:0]  a_hist, a_uhist;

    mt_gshare_bht #(
        .NR_ENTRIES(32), .HIST_BITS(3), .NUM_THREADS(2), .VLEN(32), .PC_OFFSET(1)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .ready_o(a_ready),
        .lookup_valid_i(a_lv), .lookup_tid_i(a_ltid), .lookup_pc_i(a_lpc),
        .lookup_taken_o(a_taken), .lookup_hist_o(a_hist),
        .update_valid_i(a_uv), .update_tid_i(a_utid), .update_pc_i(a_upc),
        .update_hist_i(a_uhist), .update_taken_i(a_ut), .update_mispredict_i(a_um)
    );

    // ---------------- instance B: 64 entries, 1-bit history, 4 threads, no RVC ----------------
    logic        b_flush, b_ready, b_lv, b_taken, b_uv, b_ut, b_um;
    logic [1:0]  b_ltid, b_utid;
    logic [31:0] b_lpc, b_upc;
    logic [0:0]  b_hist, b_uhist;

    mt_gshare_bht #(
        .NR_ENTRIES(64), .HIST_BITS(1), .NUM_THREADS(4), .VLEN(32), .PC_OFFSET(2)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .ready_o(b_ready),
        .lookup_valid_i(b_lv), .lookup_tid_i(b_ltid), .lookup_pc_i(b_lpc),
        .lookup_taken_o(b_taken), .lookup_hist_o(b_hist),
        .update_valid_i(b_uv), .update_tid_i(b_utid), .update_pc_i(b_upc),
        .update_hist_i(b_uhist), .update_taken_i(b_ut), .update_mispredict_i(b_um)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_flush = 0; a_lv = 0; a_ltid = 0; a_lpc = 0;
        a_uv = 0; a_utid = 0; a_upc = 0; a_uhist = 0; a_ut = 0; a_um = 0;
    endtask

    task automatic pulse_a_flush();
        a_flush = 1;
        tick();
        a_flush = 0;
    endtask

    // Counts cycles with ready low; an expired bound shows up as a wrong count.
    task automatic count_clear(output int n);
        n = 0;
        while (!a_ready && n < 200) begin
            n++;
            tick();
        end
    endtask

    typedef struct {
        logic        lv;
        logic        ltid;
        logic [31:0] lpc;
        logic        uv;
        logic        utid;
        logic [31:0] upc;
        logic [2:0]  uhist;
        logic        ut;
        logic        um;
        logic        exp_taken;
        logic [2:0]  exp_hist;
    } vec_t;

    function automatic vec_t mk(input logic lv, input logic ltid, input logic [31:0] lpc,
                                input logic uv, input logic utid, input logic [31:0] upc,
                                input logic [2:0] uhist, input logic ut, input logic um,
                                input logic et, input logic [2:0] eh);
        vec_t v;
        v.lv = lv; v.ltid = ltid; v.lpc = lpc;
        v.uv = uv; v.utid = utid; v.upc = upc; v.uhist = uhist; v.ut = ut; v.um = um;
        v.exp_taken = et; v.exp_hist = eh;
        return v;
    endfunction

    vec_t vecs [24];

    // Reference model for instance B.
    int   m_ctr [64];
    logic m_ghr [4];

    initial begin
        int n;
        int li, ui;
        logic et;

        // PC 0x100 -> index 0, 0x102 -> 1, 0x110 -> 8, 0x112 -> 9 (before history XOR).
        // Saturation at index 0.
        vecs[0]  = mk(0,0,'h100, 1,0,'h100,3'b000,1,0, 0,3'b000); // 1 -> 2
        vecs[1]  = mk(0,0,'h100, 1,0,'h100,3'b000,1,0, 1,3'b000); // 2 -> 3
        vecs[2]  = mk(0,0,'h100, 1,0,'h100,3'b000,1,0, 1,3'b000); // 3 stays
        vecs[3]  = mk(0,0,'h100, 1,0,'h100,3'b000,1,0, 1,3'b000); // 3 stays
        vecs[4]  = mk(0,0,'h100, 1,0,'h100,3'b000,0,0, 1,3'b000); // 3 -> 2
        vecs[5]  = mk(0,0,'h100, 1,0,'h100,3'b000,0,0, 1,3'b000); // 2 -> 1
        vecs[6]  = mk(0,0,'h100, 1,0,'h100,3'b000,0,0, 0,3'b000); // 1 -> 0
        vecs[7]  = mk(0,0,'h100, 1,0,'h100,3'b000,0,0, 0,3'b000); // 0 stays
        vecs[8]  = mk(0,0,'h100, 1,0,'h102,3'b000,1,0, 0,3'b000); // idx1 1 -> 2
        // Thread 0 predicts 1,0,1 -> ghr0 = 101.
        vecs[9]  = mk(1,0,'h102, 0,0,0,3'b000,0,0, 1,3'b000);     // idx1
        vecs[10] = mk(1,0,'h100, 0,0,0,3'b000,0,0, 0,3'b001);     // idx4
        vecs[11] = mk(1,0,'h112, 0,0,0,3'b000,0,0, 1,3'b010);     // 9^8 = idx1
        vecs[12] = mk(0,0,'h100, 0,0,0,3'b000,0,0, 0,3'b101);     // idx20
        vecs[13] = mk(0,1,'h100, 0,0,0,3'b000,0,0, 0,3'b000);     // thread 1 untouched
        vecs[14] = mk(1,1,'h102, 0,0,0,3'b000,0,0, 1,3'b000);     // ghr1 -> 001
        vecs[15] = mk(0,0,'h100, 0,0,0,3'b000,0,0, 0,3'b101);
        // Same-thread restore and shift: restore {10,1} wins over shift {01,0}.
        vecs[16] = mk(1,0,'h100, 1,0,'h100,3'b010,1,1, 0,3'b101); // idx8 1 -> 2
        vecs[17] = mk(0,0,'h100, 0,0,0,3'b000,0,0, 0,3'b101);
        vecs[18] = mk(0,1,'h100, 0,0,0,3'b000,0,0, 0,3'b001);
        // Different threads: shift t1 -> 010, restore t0 -> 000.
        vecs[19] = mk(1,1,'h100, 1,0,'h100,3'b000,0,1, 0,3'b001);
        vecs[20] = mk(0,0,'h100, 0,0,0,3'b000,0,0, 0,3'b000);
        vecs[21] = mk(0,1,'h100, 0,0,0,3'b000,0,0, 1,3'b010);     // idx8 = 2
        // Same index lookup and update: lookup sees the old counter.
        vecs[22] = mk(0,0,'h102, 1,0,'h102,3'b000,0,0, 1,3'b000); // idx1 2 -> 1
        vecs[23] = mk(0,0,'h102, 0,0,0,3'b000,0,0, 0,3'b000);

        idle_a();
        b_flush = 0; b_lv = 0; b_ltid = 0; b_lpc = 0;
        b_uv = 0; b_utid = 0; b_upc = 0; b_uhist = 0; b_ut = 0; b_um = 0;

        // ---------------- reset ----------------
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();
        chk("reset_ready", a_ready, 1);
        chk("reset_taken", a_taken, 0);
        chk("reset_hist", a_hist, 0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 24; i++) begin
            a_lv = vecs[i].lv; a_ltid = vecs[i].ltid; a_lpc = vecs[i].lpc;
            a_uv = vecs[i].uv; a_utid = vecs[i].utid; a_upc = vecs[i].upc;
            a_uhist = vecs[i].uhist; a_ut = vecs[i].ut; a_um = vecs[i].um;
            #1;
            $display("vec %0d: tid=%0d pc=%0h taken=%0d hist=%03b", i, a_ltid, a_lpc, a_taken, a_hist);
            chk($sformatf("vec%0d_taken", i), a_taken, vecs[i].exp_taken);
            chk($sformatf("vec%0d_hist", i), a_hist, vecs[i].exp_hist);
            tick();
        end
        idle_a();

        // ---------------- mid-run reset ----------------
        a_ltid = 1; a_lpc = 'h110;
        rst = 1;
        #3;
        chk("rst_async_taken", a_taken, 0);
        chk("rst_async_hist", a_hist, 0);
        tick();
        rst = 0;
        #1;
        chk("rst_idx8_taken", a_taken, 0);
        chk("rst_t1_hist", a_hist, 0);
        tick();
        chk("rst_ready_after", a_ready, 1);
        $display("reset: ready=%0d taken=%0d hist=%03b", a_ready, a_taken, a_hist);

        // ---------------- flush ----------------
        idle_a();
        a_uv = 1; a_upc = 'h102; a_ut = 1;
        repeat (2) tick();                          // idx1 -> 3
        idle_a();
        a_lv = 1; a_ltid = 0; a_lpc = 'h102;        // taken lookup alongside flush
        #1;
        chk("pre_flush_taken", a_taken, 1);
        pulse_a_flush();
        a_uv = 1; a_utid = 0; a_upc = 'h102; a_uhist = 0; a_ut = 1; a_um = 1;
        #1;
        chk("clear_taken_gated", a_taken, 0);
        chk("clear_ready", a_ready, 0);
        count_clear(n);
        idle_a();
        $display("flush: ready low for %0d cycles", n);
        chk("clear_len", n, 32);
        a_lpc = 'h102;
        #1;
        chk("post_clear_hist", a_hist, 0);
        chk("post_clear_taken", a_taken, 0);
        // One taken update per entry: a counter reset to 01 must then predict taken.
        for (int i = 0; i < 32; i++) begin
            a_uv = 1; a_ut = 1; a_uhist = 0; a_upc = 32'(i) << 1;
            tick();
        end
        idle_a();
        for (int i = 0; i < 32; i++) begin
            a_lpc = 32'(i) << 1;
            #1;
            chk($sformatf("cleared_ctr%0d", i), a_taken, 1);
        end
        $display("flush: all entries reinitialised");

        // ---------------- re-flush mid-clear ----------------
        pulse_a_flush();
        repeat (9) tick();
        chk("reflush_busy", a_ready, 0);
        pulse_a_flush();
        count_clear(n);
        $display("reflush: ready low for %0d further cycles", n);
        chk("reflush_len", n, 32);

        // ---------------- parameter sweep vs model ----------------
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        for (int t = 0; t < 4; t++) m_ghr[t] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            b_lv = 1'($urandom_range(0, 1)); b_ltid = 2'($urandom_range(0, 3)); b_lpc = $urandom;
            b_uv = 1'($urandom_range(0, 1)); b_utid = 2'($urandom_range(0, 3)); b_upc = $urandom;
            b_uhist = 1'($urandom_range(0, 1)); b_ut = 1'($urandom_range(0, 1));
            b_um = ($urandom_range(0, 3) == 0);
            #1;
            li = (int'(b_lpc >> 2) & 63) ^ (int'(m_ghr[b_ltid]) << 5);
            et = (m_ctr[li] >= 2);
            chk($sformatf("sweep%0d_taken", c), b_taken, et);
            chk($sformatf("sweep%0d_hist", c), b_hist, m_ghr[b_ltid]);
            ui = (int'(b_upc >> 2) & 63) ^ (int'(b_uhist) << 5);
            if (b_uv) begin
                if (b_ut && m_ctr[ui] < 3) m_ctr[ui] = m_ctr[ui] + 1;
                else if (!b_ut && m_ctr[ui] > 0) m_ctr[ui] = m_ctr[ui] - 1;
            end
            for (int t = 0; t < 4; t++) begin
                if (b_uv && b_um && int'(b_utid) == t) m_ghr[t] = b_ut;
                else if (b_lv && int'(b_ltid) == t) m_ghr[t] = et;
            end
            tick();
        end
        $display("sweep: 10000 random cycles compared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
